// File: rtl/conv2d_pkg.sv
// Shared types and constants for the conv2d frame controller.
package conv2d_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // First row/column whose 3x3 window lies entirely inside the frame.
    localparam int unsigned FIRST_ROW = 2;
    localparam int unsigned FIRST_COL = 2;

    // Position of the first result of a frame (start-of-frame marker).
    localparam int unsigned SOF_ROW = 2;
    localparam int unsigned SOF_COL = 2;

endpackage

// File: rtl/conv2d_frame_ctrl_if.sv
// Bundle of the controller's handshake and data signals.
interface conv2d_frame_ctrl_if #(
    parameter int WIDTH_P = 8
);
    // control
    logic                          start;
    logic                          busy;
    logic                          done;
    // upstream pixel stream
    logic                          pix_valid;
    logic                          pix_ready;
    logic [WIDTH_P-1:0]            pix_data;
    // datapath side
    logic                          conv_clr;
    logic                          conv_valid;
    logic                          conv_ready;
    logic [WIDTH_P-1:0]            conv_data;
    logic signed [2*WIDTH_P-1:0]   dp_gx;
    logic signed [2*WIDTH_P-1:0]   dp_gy;
    // downstream result stream
    logic                          res_valid;
    logic                          res_ready;
    logic signed [2*WIDTH_P-1:0]   res_gx;
    logic signed [2*WIDTH_P-1:0]   res_gy;
    logic                          sof;
    logic                          eol;
    logic                          eof;

    // Surrounding system: issues start, pixels, datapath results and result ready.
    modport master (
        output start, pix_valid, pix_data, conv_ready, dp_gx, dp_gy, res_ready,
        input  busy, done, pix_ready, conv_clr, conv_valid, conv_data,
               res_valid, res_gx, res_gy, sof, eol, eof
    );

    // Controller view.
    modport slave (
        input  start, pix_valid, pix_data, conv_ready, dp_gx, dp_gy, res_ready,
        output busy, done, pix_ready, conv_clr, conv_valid, conv_data,
               res_valid, res_gx, res_gy, sof, eol, eof
    );

endinterface

// File: rtl/conv2d_frame_ctrl_rowcol_counter.sv
// Raster position tracker: column counter wrapping into a row counter.
module rowcol_counter #(
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        inc,
    output logic [$clog2(HEIGHT_P)-1:0] row,
    output logic [$clog2(DEPTH_P)-1:0]  col,
    output logic                        col_last,
    output logic                        row_last,
    output logic                        frame_last
);
    localparam int COL_W = $clog2(DEPTH_P);
    localparam int ROW_W = $clog2(HEIGHT_P);

    logic [ROW_W-1:0] row_reg;
    logic [COL_W-1:0] col_reg;

    assign row        = row_reg;
    assign col        = col_reg;
    assign col_last   = (col_reg == COL_W'(DEPTH_P - 1));
    assign row_last   = (row_reg == ROW_W'(HEIGHT_P - 1));
    assign frame_last = col_last && row_last;

    // Advance one pixel position per increment, wrapping at line and frame end.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (inc) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
            end else begin
                col_reg <= col_reg + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv2d_frame_ctrl.sv
// Frame controller for a 3x3 convolution datapath: sequences a frame,
// masks border results and presents gradients with frame markers.
module conv2d_frame_ctrl
    import conv2d_pkg::*;
#(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WIDTH_P-1:0]          data_i,
    output logic                        conv_clr_o,
    output logic                        conv_valid_o,
    input  logic                        conv_ready_i,
    output logic [WIDTH_P-1:0]          conv_data_o,
    input  logic signed [2*WIDTH_P-1:0] gx_i,
    input  logic signed [2*WIDTH_P-1:0] gy_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic signed [2*WIDTH_P-1:0] gx_o,
    output logic signed [2*WIDTH_P-1:0] gy_o,
    output logic                        sof_o,
    output logic                        eol_o,
    output logic                        eof_o
);
    localparam int COL_W = $clog2(DEPTH_P);
    localparam int ROW_W = $clog2(HEIGHT_P);

    state_t state_reg, state_next;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             col_last, row_last, frame_last;

    logic cnt_clr, accept_ok, accept, qualify, res_hs;
    logic valid_reg, sof_reg, eol_reg, eof_reg, done_reg;
    logic signed [2*WIDTH_P-1:0] gx_reg, gy_reg;

    // A new pixel may enter only when the result slot is free or draining now.
    assign accept_ok = !valid_reg || ready_i;
    assign accept    = valid_i && ready_o;
    assign res_hs    = valid_reg && ready_i;
    // Border pixels only complete partial windows; their gradients are dropped.
    assign qualify   = (row >= ROW_W'(FIRST_ROW)) && (col >= COL_W'(FIRST_COL));

    assign conv_data_o = data_i;
    assign valid_o     = valid_reg;
    assign gx_o        = gx_reg;
    assign gy_o        = gy_reg;
    assign sof_o       = sof_reg;
    assign eol_o       = eol_reg;
    assign eof_o       = eof_reg;
    assign done_o      = done_reg;

    rowcol_counter #(
        .DEPTH_P  (DEPTH_P),
        .HEIGHT_P (HEIGHT_P)
    ) u_rowcol (
        .clk        (clk_i),
        .rst        (rst_i),
        .clr        (cnt_clr),
        .inc        (accept),
        .row        (row),
        .col        (col),
        .col_last   (col_last),
        .row_last   (row_last),
        .frame_last (frame_last)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state: start only honoured in IDLE; last pixel accept enters DRAIN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start_i) state_next = ST_CLEAR;
            ST_CLEAR:  state_next = ST_ACTIVE;
            ST_ACTIVE: if (accept && frame_last) state_next = ST_DRAIN;
            ST_DRAIN:  if (res_hs) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs: window clear in CLEAR, pixel flow only in ACTIVE.
    always_comb begin
        busy_o       = (state_reg != ST_IDLE);
        ready_o      = 1'b0;
        conv_valid_o = 1'b0;
        conv_clr_o   = 1'b0;
        cnt_clr      = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                conv_clr_o = 1'b1;
                cnt_clr    = 1'b1;
            end
            ST_ACTIVE: begin
                ready_o      = accept_ok && conv_ready_i;
                conv_valid_o = valid_i && accept_ok;
            end
            default: ;
        endcase
    end

    // Result slot: loaded by a qualifying accept, emptied by the output handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= 1'b0;
            sof_reg   <= 1'b0;
            eol_reg   <= 1'b0;
            eof_reg   <= 1'b0;
            gx_reg    <= '0;
            gy_reg    <= '0;
        end else if (accept && qualify) begin
            valid_reg <= 1'b1;
            sof_reg   <= (row == ROW_W'(SOF_ROW)) && (col == COL_W'(SOF_COL));
            eol_reg   <= col_last;
            eof_reg   <= frame_last;
            gx_reg    <= gx_i;
            gy_reg    <= gy_i;
        end else if (res_hs) begin
            valid_reg <= 1'b0;
            sof_reg   <= 1'b0;
            eol_reg   <= 1'b0;
            eof_reg   <= 1'b0;
        end
    end

    // Frame completion pulse, one cycle after the final result leaves.
    always_ff @(posedge clk_i) begin
        if (rst_i) done_reg <= 1'b0;
        else       done_reg <= (state_reg == ST_DRAIN) && res_hs;
    end

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Randomized scoreboard bench for conv2d_frame_ctrl (4x4 frames).
module tb_conv2d_frame_ctrl;
    localparam int W    = 8;
    localparam int GW   = 2 * W;
    localparam int D    = 4;
    localparam int H    = 4;
    localparam int NRES = (H - 2) * (D - 2);

    typedef struct {
        int gx;
        int gy;
        bit sof;
        bit eol;
        bit eof;
    } exp_t;

    logic clk;
    logic rst;

    conv2d_frame_ctrl_if #(.WIDTH_P(W)) bus ();

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   img [H][D];
    int   clr_cnt = 0, res_cnt = 0, done_cnt = 0, acc_idx = 0;
    int   last_hs_cycle = -10;
    int   stall_left = 0;
    int   prev_gx = 0;
    bit   lat_mode = 0, lat_pending = 0, lat_exp = 0;
    bit   stall_mode = 0, stall_done = 0, rnd_mode = 0, prev_stall = 0;

    conv2d_frame_ctrl #(
        .WIDTH_P  (W),
        .DEPTH_P  (D),
        .HEIGHT_P (H)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (bus.start),
        .busy_o       (bus.busy),
        .done_o       (bus.done),
        .valid_i      (bus.pix_valid),
        .ready_o      (bus.pix_ready),
        .data_i       (bus.pix_data),
        .conv_clr_o   (bus.conv_clr),
        .conv_valid_o (bus.conv_valid),
        .conv_ready_i (bus.conv_ready),
        .conv_data_o  (bus.conv_data),
        .gx_i         (bus.dp_gx),
        .gy_i         (bus.dp_gy),
        .valid_o      (bus.res_valid),
        .ready_i      (bus.res_ready),
        .gx_o         (bus.res_gx),
        .gy_o         (bus.res_gy),
        .sof_o        (bus.sof),
        .eol_o        (bus.eol),
        .eof_o        (bus.eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic bit is_qual(int r, int c);
        return (r >= 2) && (c >= 2);
    endfunction

    // Sobel gradients of the 3x3 window whose bottom-right pixel is (r,c).
    function automatic int sobel_gx(int r, int c);
        return (img[r-2][c] + 2*img[r-1][c] + img[r][c])
             - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    endfunction

    function automatic int sobel_gy(int r, int c);
        return (img[r][c-2] + 2*img[r][c-1] + img[r][c])
             - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    endfunction

    // Monitor: scoreboard pops, hold/stall checks, latency and done timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.conv_clr) clr_cnt++;
            if (lat_pending) begin
                chk("latency_valid_o", int'(bus.res_valid), int'(lat_exp));
                lat_pending = 0;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                acc_idx++;
                chk("conv_valid_o", int'(bus.conv_valid), 1);
                chk("conv_data_o", int'(bus.conv_data), int'(bus.pix_data));
                if (lat_mode) begin
                    lat_pending = 1;
                    lat_exp = is_qual((acc_idx - 1) / D, (acc_idx - 1) % D);
                end
            end
            if (prev_stall && bus.res_valid)
                chk("hold_gx", int'(bus.res_gx), prev_gx);
            if (bus.res_valid && !bus.res_ready)
                chk("stall_ready_o", int'(bus.pix_ready), 0);
            prev_stall = bus.res_valid && !bus.res_ready;
            prev_gx    = int'(bus.res_gx);
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("gx_o", int'(bus.res_gx), mon_e.gx);
                    chk("gy_o", int'(bus.res_gy), mon_e.gy);
                    chk("sof_o", int'(bus.sof), int'(mon_e.sof));
                    chk("eol_o", int'(bus.eol), int'(mon_e.eol));
                    chk("eof_o", int'(bus.eof), int'(mon_e.eof));
                end
                res_cnt++;
                last_hs_cycle = cycle;
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_timing", cycle, last_hs_cycle + 1);
            end
        end
    end

    // Downstream/datapath readiness: steady, random, or a 5-cycle stall at result 1.
    initial begin
        bus.res_ready  = 1'b1;
        bus.conv_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.res_ready = 1'b0;
                stall_left--;
            end else if (stall_mode && !stall_done && bus.res_valid) begin
                stall_done    = 1;
                stall_left    = 4;
                bus.res_ready = 1'b0;
            end else if (rnd_mode) begin
                bus.res_ready  = ($urandom_range(0, 3) != 0);
                bus.conv_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.res_ready  = 1'b1;
                bus.conv_ready = 1'b1;
            end
        end
    end

    // Issue a frame (kind 0: 1..16, 1: constant 50, 2: random) of npix pixels.
    task automatic run_frame(input int kind, input int npix, input bit gaps, input bit mid_start);
        int  r, c;
        bit  acc;
        exp_t e;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < D; j++)
                img[i][j] = (kind == 0) ? (i * D + j + 1) :
                            (kind == 1) ? 50 : int'($urandom_range(0, 255));
        clr_cnt = 0; res_cnt = 0; done_cnt = 0; acc_idx = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < npix; k++) begin
            r = k / D;
            c = k % D;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.pix_valid = 1'b0;
                    bus.dp_gx = GW'($urandom);
                    @(posedge clk); #1;
                end
            end
            bus.pix_valid = 1'b1;
            bus.pix_data  = W'(img[r][c]);
            if (is_qual(r, c)) begin
                bus.dp_gx = GW'(sobel_gx(r, c));
                bus.dp_gy = GW'(sobel_gy(r, c));
            end else begin
                bus.dp_gx = GW'($urandom);
                bus.dp_gy = GW'($urandom);
            end
            if (mid_start && k == 6) bus.start = 1'b1;
            acc = 0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                if (bus.pix_ready) begin
                    acc = 1;
                    if (is_qual(r, c)) begin
                        e.gx  = sobel_gx(r, c);
                        e.gy  = sobel_gy(r, c);
                        e.sof = (r == 2) && (c == 2);
                        e.eol = (c == D - 1);
                        e.eof = (r == H - 1) && (c == D - 1);
                        exp_q.push_back(e);
                    end
                end
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        bus.pix_valid = 1'b0;
        if (npix == D * H) begin
            for (int t = 0; t < 300 && done_cnt == 0; t++) @(posedge clk);
            repeat (3) @(posedge clk);
            chk("done_count", done_cnt, 1);
            chk("result_count", res_cnt, NRES);
            chk("clr_pulses", clr_cnt, 1);
            chk("queue_left", exp_q.size(), 0);
            @(negedge clk);
            chk("idle_busy_o", int'(bus.busy), 0);
            $display("frame kind=%0d results=%0d done=%0d clr=%0d", kind, res_cnt, done_cnt, clr_cnt);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.dp_gx     = '0;
        bus.dp_gy     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_o", int'(bus.busy), 0);
        chk("rst_valid_o", int'(bus.res_valid), 0);
        chk("rst_done_o", int'(bus.done), 0);
        chk("rst_ready_o", int'(bus.pix_ready), 0);
        chk("rst_conv_clr_o", int'(bus.conv_clr), 0);
        chk("rst_markers", int'({bus.sof, bus.eol, bus.eof}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_without_start", int'(bus.busy), 0);

        // Ramp frame, back-to-back, with per-accept latency checks.
        lat_mode = 1;
        run_frame(0, D * H, 0, 0);
        lat_mode = 0;

        // Constant frame: zero gradients, marker placement.
        run_frame(1, D * H, 0, 0);

        // Downstream stall at the first result.
        stall_mode = 1; stall_done = 0;
        run_frame(2, D * H, 0, 0);
        stall_mode = 0;
        chk("stall_applied", int'(stall_done), 1);

        // Reset after pixel 9, then a fresh frame.
        run_frame(2, 9, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy_o", int'(bus.busy), 0);
        chk("midrst_valid_o", int'(bus.res_valid), 0);
        chk("midrst_queue", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid-frame reset applied after 9 pixels");
        run_frame(2, D * H, 0, 0);

        // Random handshakes with a start request during ACTIVE.
        rnd_mode = 1;
        run_frame(2, D * H, 1, 1);

        // Further random frames.
        for (int f = 0; f < 4; f++) run_frame(2, D * H, 1, 0);
        rnd_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
